// File: rtl/cb_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cb_bus_arbiter_pkg
// Brief    : Shared types and master index constants for the core-bus arbiter
// Revision : 1.0
// ============================================================================
package cb_bus_arbiter_pkg;

    localparam int CB_ADDR_WIDTH = 32;
    localparam int CB_DATA_WIDTH = 32;
    localparam int CB_STRB_WIDTH = CB_DATA_WIDTH / 8;

    localparam logic ARB_M_FETCH = 1'b0;
    localparam logic ARB_M_LSU   = 1'b1;

    typedef struct packed {
        logic                     we;
        logic [CB_ADDR_WIDTH-1:0] addr;
        logic [CB_DATA_WIDTH-1:0] wdata;
        logic [CB_STRB_WIDTH-1:0] wstrb;
    } s_arb_req_t;

    typedef struct packed {
        logic [CB_DATA_WIDTH-1:0] rdata;
        logic                     err;
    } s_arb_rsp_t;

    // Two-way round robin: on a tie the master that did not win last time goes.
    function automatic logic rr_pick(input logic [1:0] valid, input logic last_grant);
        if (valid == 2'b11) begin
            return ~last_grant;
        end
        return valid[1];
    endfunction

endpackage
`default_nettype wire

// File: rtl/cb_bus_arbiter_id_fifo.sv
`default_nettype none
// ============================================================================
// Module   : arb_id_fifo
// Brief    : Synchronous FIFO of 1-bit master IDs for in-order response routing
// Revision : 1.0
// ============================================================================
module arb_id_fifo #(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_din,
    output logic             o_dout,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    localparam int               PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] c_last_ptr = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] c_depth    = CNT_W'(DEPTH);

    logic [DEPTH-1:0] r_mem;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == c_depth);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_dout    = r_mem[r_rd_ptr];
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    // Explicit wrap keeps non-power-of-two depths correct as well.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == c_last_ptr) ? '0 : ptr + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_mem    <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_din;
                r_wr_ptr        <= next_ptr(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/cb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cb_bus_arbiter
// Brief    : Round-robin sharing of one core-bus slave between fetch and LSU
// Revision : 1.0
// ============================================================================
module cb_bus_arbiter
    import cb_bus_arbiter_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic       [1:0]                 m_req_valid_i,
    output logic       [1:0]                 m_req_ready_o,
    input  s_arb_req_t [1:0]                 m_req_i,
    output logic       [1:0]                 m_rsp_valid_o,
    input  logic       [1:0]                 m_rsp_ready_i,
    output s_arb_rsp_t [1:0]                 m_rsp_o,
    output logic                             s_req_valid_o,
    input  logic                             s_req_ready_i,
    output s_arb_req_t                       s_req_o,
    input  logic                             s_rsp_valid_i,
    output logic                             s_rsp_ready_o,
    input  s_arb_rsp_t                       s_rsp_i,
    output logic                             err_unexp_rsp_o,
    output logic [$clog2(MAX_OUTSTANDING):0] outstanding_o
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

    generate
        if (ADDR_WIDTH != CB_ADDR_WIDTH || DATA_WIDTH != CB_DATA_WIDTH) begin : g_width_mismatch
            $error("cb_bus_arbiter: ADDR_WIDTH/DATA_WIDTH must match the package payload widths");
        end
    endgenerate

    logic r_last_grant;
    logic r_locked;
    logic r_lock_idx;
    logic r_err_unexp;
    logic w_gnt;
    logic w_full;
    logic w_empty;
    logic w_head;
    logic w_handshake;
    logic w_pop;

    // Request path uses only master inputs, slave ready and registered state.
    assign w_gnt         = r_locked ? r_lock_idx : rr_pick(m_req_valid_i, r_last_grant);
    assign s_req_valid_o = ~w_full & m_req_valid_i[w_gnt];
    assign s_req_o       = m_req_i[w_gnt];
    assign w_handshake   = s_req_valid_o & s_req_ready_i;

    always_comb begin
        m_req_ready_o = 2'b00;
        if (!w_full) begin
            m_req_ready_o[w_gnt] = s_req_ready_i;
        end
    end

    always_comb begin
        m_rsp_valid_o = 2'b00;
        s_rsp_ready_o = 1'b1;
        if (!w_empty) begin
            m_rsp_valid_o[w_head] = s_rsp_valid_i;
            s_rsp_ready_o         = m_rsp_ready_i[w_head];
        end
    end

    assign w_pop           = s_rsp_valid_i & s_rsp_ready_o & ~w_empty;
    assign m_rsp_o         = {s_rsp_i, s_rsp_i};
    assign err_unexp_rsp_o = r_err_unexp;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= ARB_M_LSU;
            r_locked     <= 1'b0;
            r_lock_idx   <= ARB_M_FETCH;
            r_err_unexp  <= 1'b0;
        end else begin
            r_err_unexp <= s_rsp_valid_i & w_empty;
            if (w_handshake) begin
                r_last_grant <= w_gnt;
                r_locked     <= 1'b0;
            end else if (s_req_valid_o) begin
                r_locked   <= 1'b1;
                r_lock_idx <= w_gnt;
            end
        end
    end

    arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .CNT_W (CNT_W)
    ) u_id_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_handshake),
        .i_pop   (w_pop),
        .i_din   (w_gnt),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (outstanding_o)
    );

endmodule
`default_nettype wire

// File: tb/tb_cb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cb_bus_arbiter
// Brief    : Directed and random checks of cb_bus_arbiter against a queue model
// Revision : 1.0
// ============================================================================
module tb_cb_bus_arbiter;
    import cb_bus_arbiter_pkg::*;

    localparam int MAXO = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [1:0]       m_req_valid = 2'b00;
    logic [1:0]       m_req_ready_o;
    s_arb_req_t [1:0] m_req = '0;
    logic [1:0]       m_rsp_valid_o;
    logic [1:0]       m_rsp_ready = 2'b00;
    s_arb_rsp_t [1:0] m_rsp_o;
    logic             s_req_valid_o;
    logic             s_req_ready = 1'b0;
    s_arb_req_t       s_req_o;
    logic             s_rsp_valid = 1'b0;
    logic             s_rsp_ready_o;
    s_arb_rsp_t       s_rsp = '0;
    logic             err_unexp_rsp_o;
    logic [1:0]       outstanding_o;

    int total = 0;
    int bad   = 0;

    // Reference model: queue of owners of accepted-but-unanswered requests.
    bit q[$];
    bit last_g   = 1'b1;
    bit lk       = 1'b0;
    bit lk_idx   = 1'b0;
    bit errp     = 1'b0;
    bit pushed   = 1'b0;
    bit pushed_g = 1'b0;
    bit pend[2];

    cb_bus_arbiter #(
        .MAX_OUTSTANDING (MAXO),
        .ADDR_WIDTH      (32),
        .DATA_WIDTH      (32)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .m_req_valid_i   (m_req_valid),
        .m_req_ready_o   (m_req_ready_o),
        .m_req_i         (m_req),
        .m_rsp_valid_o   (m_rsp_valid_o),
        .m_rsp_ready_i   (m_rsp_ready),
        .m_rsp_o         (m_rsp_o),
        .s_req_valid_o   (s_req_valid_o),
        .s_req_ready_i   (s_req_ready),
        .s_req_o         (s_req_o),
        .s_rsp_valid_i   (s_rsp_valid),
        .s_rsp_ready_o   (s_rsp_ready_o),
        .s_rsp_i         (s_rsp),
        .err_unexp_rsp_o (err_unexp_rsp_o),
        .outstanding_o   (outstanding_o)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic s_arb_req_t rnd_req();
        s_arb_req_t r;
        r.we    = 1'($urandom_range(0, 1));
        r.addr  = $urandom;
        r.wdata = $urandom;
        r.wstrb = 4'($urandom);
        return r;
    endfunction

    // Called at the falling edge with inputs applied; checks, then advances one clock.
    task automatic tick();
        bit full, empty, g, h, sv, srr;
        logic [1:0] exp_rdy, exp_rv;
        #1;
        full  = (q.size() == MAXO);
        empty = (q.size() == 0);
        if (lk)                       g = lk_idx;
        else if (m_req_valid == 2'b11) g = ~last_g;
        else                          g = m_req_valid[1];
        sv      = !full && m_req_valid[g];
        exp_rdy = 2'b00;
        if (!full) exp_rdy[g] = s_req_ready;
        h      = empty ? 1'b0 : q[0];
        exp_rv = 2'b00;
        if (!empty && s_rsp_valid) exp_rv[h] = 1'b1;
        srr = empty ? 1'b1 : m_rsp_ready[h];

        check_val("s_req_valid", s_req_valid_o, sv);
        if (sv) check_val("s_req_payload", s_req_o, m_req[g]);
        check_val("m_req_ready", m_req_ready_o, exp_rdy);
        check_val("m_rsp_valid", m_rsp_valid_o, exp_rv);
        check_val("s_rsp_ready", s_rsp_ready_o, srr);
        if (exp_rv != 2'b00) check_val("m_rsp_payload", m_rsp_o[h], s_rsp);
        check_val("outstanding", outstanding_o, q.size());
        check_val("err_unexp", err_unexp_rsp_o, errp);

        pushed = 1'b0;
        if (rst) begin
            q.delete();
            last_g = 1'b1;
            lk     = 1'b0;
            errp   = 1'b0;
        end else begin
            errp = s_rsp_valid && empty;
            if (!empty && s_rsp_valid && srr) void'(q.pop_front());
            if (sv && s_req_ready) begin
                q.push_back(g);
                last_g   = g;
                lk       = 1'b0;
                pushed   = 1'b1;
                pushed_g = g;
            end else if (sv) begin
                lk     = 1'b1;
                lk_idx = g;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; m_req_valid = 2'b00; s_req_ready = 1'b0;
        s_rsp_valid = 1'b0; m_rsp_ready = 2'b00;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic drain();
        m_req_valid = 2'b00; s_rsp_valid = 1'b1; m_rsp_ready = 2'b11;
        tick(); tick();
        s_rsp_valid = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_outstanding", outstanding_o, 0);
        check_val("rst_s_req_valid", s_req_valid_o, 0);
        check_val("rst_m_req_ready", m_req_ready_o, 0);
        check_val("rst_err", err_unexp_rsp_o, 0);
        rst = 1'b0;

        // Alternating grants until the ID FIFO fills.
        m_req[0] = '{we: 1'b0, addr: 32'h100, wdata: 32'h0, wstrb: 4'h0};
        m_req[1] = '{we: 1'b0, addr: 32'h200, wdata: 32'h0, wstrb: 4'h0};
        m_req_valid = 2'b11; s_req_ready = 1'b1;
        repeat (4) tick();
        check_val("full_count", outstanding_o, 2);

        // Pop while full: no accept that cycle, accept on the next.
        m_req_valid = 2'b01; s_rsp_valid = 1'b1; m_rsp_ready = 2'b11;
        tick();
        check_val("pop_count", outstanding_o, 1);
        s_rsp_valid = 1'b0;
        tick();
        check_val("refill_count", outstanding_o, 2);
        drain();

        // In-order response routing with a stalled M0 response.
        m_req_valid = 2'b01; tick();
        m_req_valid = 2'b10; tick();
        m_req_valid = 2'b00;
        s_rsp_valid = 1'b1; s_rsp = '{rdata: 32'h11, err: 1'b0}; m_rsp_ready = 2'b10;
        #1;
        check_val("rsp_stall", s_rsp_ready_o, 0);
        tick(); tick();
        m_rsp_ready = 2'b11;
        #1;
        check_val("rsp_m0_valid", m_rsp_valid_o, 2'b01);
        check_val("rsp_m0_data", m_rsp_o[0].rdata, 32'h11);
        tick();
        s_rsp = '{rdata: 32'h22, err: 1'b1};
        #1;
        check_val("rsp_m1_valid", m_rsp_valid_o, 2'b10);
        check_val("rsp_m1_data", m_rsp_o[1], {32'h22, 1'b1});
        tick();
        s_rsp_valid = 1'b0;

        // Grant lock on a stalled M1 write.
        do_reset();
        m_req[1] = '{we: 1'b1, addr: 32'h2000_0004, wdata: 32'hDEAD_BEEF, wstrb: 4'hF};
        m_req_valid = 2'b10; s_req_ready = 1'b0;
        tick();
        m_req_valid = 2'b11;
        tick(); tick();
        s_req_ready = 1'b1;
        #1;
        check_val("lock_payload", s_req_o, {1'b1, 32'h2000_0004, 32'hDEAD_BEEF, 4'hF});
        check_val("lock_ready", m_req_ready_o, 2'b10);
        tick();
        m_req_valid = 2'b01;
        tick();
        drain();

        // Unexpected response with nothing outstanding.
        s_rsp_valid = 1'b1;
        #1;
        check_val("unexp_ready", s_rsp_ready_o, 1);
        check_val("unexp_no_valid", m_rsp_valid_o, 0);
        tick();
        s_rsp_valid = 1'b0;
        check_val("unexp_pulse", err_unexp_rsp_o, 1);
        tick();
        check_val("unexp_pulse_end", err_unexp_rsp_o, 0);

        // Reset with two outstanding, then a stale response.
        m_req_valid = 2'b11; s_req_ready = 1'b1;
        tick(); tick();
        m_req_valid = 2'b00;
        check_val("pre_rst_count", outstanding_o, 2);
        rst = 1'b1; tick(); rst = 1'b0;
        s_rsp_valid = 1'b1;
        #1;
        check_val("post_rst_count", outstanding_o, 0);
        check_val("stale_no_valid", m_rsp_valid_o, 0);
        tick();
        s_rsp_valid = 1'b0;
        check_val("stale_flag", err_unexp_rsp_o, 1);
        m_req_valid = 2'b11;
        #1;
        check_val("tie_to_m0", s_req_o, m_req[0]);
        tick();
        m_req_valid = 2'b00;
        do_reset();

        // Random traffic; masters hold valid and payload until accepted.
        pend[0] = 1'b0; pend[1] = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && $urandom_range(0, 99) < 45) begin
                    pend[i]  = 1'b1;
                    m_req[i] = rnd_req();
                end
            end
            m_req_valid = {pend[1], pend[0]};
            s_req_ready = ($urandom_range(0, 99) < 60);
            s_rsp_valid = ($urandom_range(0, 99) < 40);
            s_rsp       = {32'($urandom), 1'($urandom_range(0, 1))};
            m_rsp_ready = 2'($urandom);
            rst         = ($urandom_range(0, 299) == 0);
            tick();
            if (pushed) pend[pushed_g] = 1'b0;
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cb_bus_arbiter.md
Name: cb_bus_arbiter

Overview:
Shares one core-bus slave port between the instruction-fetch requester (M0) and the load-store requester (M1), so that a single-port memory or interconnect can serve the core.
- Arbitrates requests using round-robin.
- Holds the grant stable until each request handshake completes.
- Tracks outstanding transactions in an in-order ID FIFO and routes each response back to its originator.
- Sits between the fetch/LSU core-bus outputs and the bus bridge.

Parameters:
MAX_OUTSTANDING, 2, max requests accepted but not yet answered; power of two, >=1
ADDR_WIDTH, 32, request address width
DATA_WIDTH, 32, read/write data width

Ports:
clk  input  1  core clock
rst  input  1  reset; synchronous, active-high (one clock domain)
m_req_valid_i  input  2  request valid per master; index 0=fetch, 1=lsu
m_req_ready_o  output  2  request accepted per master
m_req_i  input  2 x s_arb_req_t  per-master payload: we, addr[ADDR_WIDTH], wdata[DATA_WIDTH], wstrb[DATA_WIDTH/8]
m_rsp_valid_o  output  2  response valid per master
m_rsp_ready_i  input  2  master can take the response
m_rsp_o  output  2 x s_arb_rsp_t  response payload: rdata[DATA_WIDTH], err; driven to both masters
s_req_valid_o  output  1  request valid to the slave
s_req_ready_i  input  1  slave accepts the request
s_req_o  output  s_arb_req_t  forwarded payload of the granted master
s_rsp_valid_i  input  1  slave response valid; exactly one response per request, in order
s_rsp_ready_o  output  1  arbiter takes the response
s_rsp_i  input  s_arb_rsp_t  slave response payload
err_unexp_rsp_o  output  1  one-cycle pulse: a response arrived with no outstanding request
outstanding_o  output  $clog2(MAX_OUTSTANDING)+1  current number of outstanding transactions

Behaviour:
- Reset (rst=1 at a clk edge):
  - ID FIFO is emptied; outstanding_o=0; grant lock is cleared.
  - last_grant is set to M1, so the first tie goes to M0.
  - All valid/ready outputs are 0 during and after reset until inputs request otherwise.
  - err_unexp_rsp_o=0.
- Request path (zero-latency, combinational forwarding):
  - When the FIFO is not full and no grant is locked, select among the asserted m_req_valid_i. A single requester wins; on a tie the master other than last_grant wins.
  - s_req_valid_o = valid of the granted master. s_req_o = its payload.
  - m_req_ready_o[g] = s_req_ready_i; the other master's ready is 0.
- Handshake (s_req_valid_o & s_req_ready_i):
  - Push the grant index into the FIFO.
  - last_grant <= g; clear the lock.
- Grant lock: if the granted request is valid but not ready, register lock=1 with the locked index. The grant may not change until the handshake completes, even if the other master asserts valid.
- FIFO full, based on the registered count:
  - s_req_valid_o=0 and m_req_ready_o=0, even if a pop occurs in the same cycle.
  - A locked grant also drops s_req_valid_o while full, and resumes unchanged once space frees.
- Response path:
  - When the FIFO is not empty, head h = index at the FIFO head.
  - m_rsp_valid_o[h] = s_rsp_valid_i; the other master's response valid is 0.
  - s_rsp_ready_o = m_rsp_ready_i[h].
  - Pop on s_rsp_valid_i & s_rsp_ready_o.
- Response with FIFO empty: s_rsp_ready_o=1, the response is dropped, and err_unexp_rsp_o pulses on the next cycle.
- Simultaneous push and pop in one cycle: count is unchanged; pointers wrap modulo MAX_OUTSTANDING.
- Writes also consume a FIFO slot and produce a response; err is forwarded unchanged.
- Reset mid-transaction: all tracking is discarded. Responses still arriving afterwards are treated as unexpected (dropped, flagged).
- No combinational path from s_rsp_* to s_req_*. The request path depends only on m_req_*, s_req_ready_i and registered state.

Decomposition:
- Shared package holds:
  - s_arb_req_t and s_arb_rsp_t.
  - The master index constants ARB_M_FETCH=0 and ARB_M_LSU=1.
- One natural sub-module: arb_id_fifo, a parameterised synchronous FIFO of 1-bit IDs with push/pop/full/empty/count.
- Round-robin selection and grant lock live in cb_bus_arbiter itself.

Test Plan:
- After reset, M0 and M1 both valid, s_req_ready_i=1 every cycle → grants alternate M0,M1,M0,M1. outstanding_o reaches 2, then request readies are 0 until a response pops.
- Only M1 valid with addr 0x2000_0004, we=1, wdata 0xDEAD_BEEF, wstrb 0xF; s_req_ready_i=0 for 3 cycles → s_req_o stable all 3 cycles, M0 asserting mid-way is not granted, and the handshake completes in cycle 4.
- Issue M0 read then M1 read; slave returns rdata 0x11 then 0x22 → M0 receives 0x11 and M1 receives 0x22. Hold m_rsp_ready_i[0]=0 for 2 cycles → s_rsp_ready_o=0 over those cycles.
- FIFO full with MAX_OUTSTANDING=2; a response pops in the same cycle as a new M0 valid → no accept that cycle, accept on the next cycle, outstanding_o goes 2→1→2.
- s_rsp_valid_i=1 with the FIFO empty → s_rsp_ready_o=1, no m_rsp_valid_o, err_unexp_rsp_o=1 for exactly one cycle.
- Assert rst with 2 outstanding, then deliver a stale response → outstanding_o=0, the stale response is dropped and flagged, and the next tie is granted to M0.
